// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data, redirect request and the decode-side
// handshake with its held instruction, error pulse and handoff counter.
interface instr_fetch_if;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;
    logic [31:0] fetch_count;

    // Fetch unit side
    modport master (
        output instr_addr,
        input  instr_data,
        input  redirect_en,
        input  redirect_addr,
        input  out_ready,
        output out_valid,
        output if_pc,
        output if_instr,
        output misalign_err,
        output fetch_count
    );

    // ROM / decode / branch-unit side
    modport slave (
        input  instr_addr,
        output instr_data,
        output redirect_en,
        output redirect_addr,
        output out_ready,
        input  out_valid,
        input  if_pc,
        input  if_instr,
        input  misalign_err,
        input  fetch_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-stage instruction fetch: PC register driving an asynchronous ROM,
// one output register toward decode with a valid/ready stall, redirect flush
// with one bubble, misaligned-target pulse and a handoff counter.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    // Low bits are forced to zero so a mis-set parameter cannot create an unaligned PC.
    localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q,          pc_d;
    logic [31:0] if_pc_q,       if_pc_d;
    logic [31:0] if_instr_q,    if_instr_d;
    logic        out_valid_q,   out_valid_d;
    logic        misalign_q,    misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        load;
    logic        handoff;

    // Output register may accept a new word when empty or being drained.
    assign load    = !out_valid_q || bus.out_ready;
    assign handoff = out_valid_q && bus.out_ready;

    // Next-state: redirect flushes, otherwise load advances, otherwise stall.
    always_comb begin
        pc_d        = pc_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        out_valid_d = out_valid_q;
        misalign_d  = 1'b0;
        if (bus.redirect_en) begin
            // if_pc is left alone; only valid/instr mark the bubble.
            pc_d        = {bus.redirect_addr[31:2], 2'b00};
            out_valid_d = 1'b0;
            if_instr_d  = NOP_INSTR;
            misalign_d  = |bus.redirect_addr[1:0];
        end else if (load) begin
            if_pc_d     = pc_q;
            if_instr_d  = bus.instr_data;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
        end
    end

    // A handoff still counts on a redirect edge; the held word left the stage.
    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, handoff};
    end

    // State registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= PC_RST;
            if_pc_q       <= 32'd0;
            if_instr_q    <= NOP_INSTR;
            out_valid_q   <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            out_valid_q   <= out_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.instr_addr   = pc_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.if_pc        = if_pc_q;
    assign bus.if_instr     = if_instr_q;
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a table of hand-derived per-edge vectors covering
// reset, stall, redirect, misalignment and wrap, then a randomised run
// checked against a small reference model with an in-order scoreboard.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;
    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: two fixed words at 0/4, a reversible pattern elsewhere.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0011_0233;
        if (a == 32'h4) return 32'h4011_02B3;
        return a ^ 32'h1357_9BDF;
    endfunction

    assign bus.instr_data = rom_word(bus.instr_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        re;
        logic [31:0] ra;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic re, input logic [31:0] ra,
                                input logic rdy, input logic v, input logic [31:0] p,
                                input logic [31:0] ins, input logic [31:0] ad,
                                input logic m, input logic [31:0] c);
        vec_t r;
        r.rst = rst; r.re = re; r.ra = ra; r.rdy = rdy;
        r.e_vld = v; r.e_pc = p; r.e_instr = ins; r.e_addr = ad; r.e_mis = m; r.e_cnt = c;
        return r;
    endfunction

    vec_t vecs[21];

    // Scoreboard of {pc, instr} fetched but not yet handed to decode.
    logic [63:0] sbq[$];
    logic [31:0] m_pc;
    logic        m_vld;
    logic        m_mis;
    logic [31:0] m_cnt;

    initial begin
        reset             = 1'b1;
        bus.redirect_en   = 1'b0;
        bus.redirect_addr = 32'h0;
        bus.out_ready     = 1'b0;

        //              rst re ra            rdy  vld if_pc         if_instr       instr_addr    mis cnt
        vecs[0]  = mk(1, 0, 32'h0,        1,  0, 32'h0,        NOP,           32'h0,        0, 0);
        vecs[1]  = mk(0, 0, 32'h0,        1,  1, 32'h0,        32'h0011_0233, 32'h4,        0, 0);
        vecs[2]  = mk(0, 0, 32'h0,        1,  1, 32'h4,        32'h4011_02B3, 32'h8,        0, 1);
        vecs[3]  = mk(0, 0, 32'h0,        0,  1, 32'h4,        32'h4011_02B3, 32'h8,        0, 1);
        vecs[4]  = mk(0, 0, 32'h0,        0,  1, 32'h4,        32'h4011_02B3, 32'h8,        0, 1);
        vecs[5]  = mk(0, 0, 32'h0,        0,  1, 32'h4,        32'h4011_02B3, 32'h8,        0, 1);
        vecs[6]  = mk(0, 0, 32'h0,        1,  1, 32'h8,        32'h1357_9BD7, 32'hC,        0, 2);
        vecs[7]  = mk(0, 1, 32'h40,       1,  0, 32'h8,        NOP,           32'h40,       0, 3);
        vecs[8]  = mk(0, 0, 32'h0,        1,  1, 32'h40,       32'h1357_9B9F, 32'h44,       0, 3);
        vecs[9]  = mk(0, 1, 32'h42,       1,  0, 32'h40,       NOP,           32'h40,       1, 4);
        vecs[10] = mk(0, 0, 32'h0,        1,  1, 32'h40,       32'h1357_9B9F, 32'h44,       0, 4);
        vecs[11] = mk(0, 1, 32'hFFFF_FFFC,1,  0, 32'h40,       NOP,           32'hFFFF_FFFC,0, 5);
        vecs[12] = mk(0, 0, 32'h0,        1,  1, 32'hFFFF_FFFC,32'hECA8_6423, 32'h0,        0, 5);
        vecs[13] = mk(0, 0, 32'h0,        1,  1, 32'h0,        32'h0011_0233, 32'h4,        0, 6);
        vecs[14] = mk(0, 0, 32'h0,        1,  1, 32'h4,        32'h4011_02B3, 32'h8,        0, 7);
        vecs[15] = mk(0, 0, 32'h0,        0,  1, 32'h4,        32'h4011_02B3, 32'h8,        0, 7);
        vecs[16] = mk(0, 1, 32'h10,       0,  0, 32'h4,        NOP,           32'h10,       0, 7);
        vecs[17] = mk(0, 0, 32'h0,        0,  1, 32'h10,       32'h1357_9BCF, 32'h14,       0, 7);
        vecs[18] = mk(0, 0, 32'h0,        0,  1, 32'h10,       32'h1357_9BCF, 32'h14,       0, 7);
        vecs[19] = mk(1, 1, 32'h80,       0,  0, 32'h0,        NOP,           32'h0,        0, 0);
        vecs[20] = mk(0, 0, 32'h0,        1,  1, 32'h0,        32'h0011_0233, 32'h4,        0, 0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            reset             = vecs[i].rst;
            bus.redirect_en   = vecs[i].re;
            bus.redirect_addr = vecs[i].ra;
            bus.out_ready     = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i),    {31'd0, bus.out_valid},    {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d_if_pc", i),        bus.if_pc,                 vecs[i].e_pc);
            chk($sformatf("v%0d_if_instr", i),     bus.if_instr,              vecs[i].e_instr);
            chk($sformatf("v%0d_instr_addr", i),   bus.instr_addr,            vecs[i].e_addr);
            chk($sformatf("v%0d_misalign_err", i), {31'd0, bus.misalign_err}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d_fetch_count", i),  bus.fetch_count,           vecs[i].e_cnt);
        end

        // Randomised section: restart from reset, then free-run against the model.
        @(negedge clk);
        reset           = 1'b1;
        bus.redirect_en = 1'b0;
        bus.out_ready   = 1'b0;
        @(posedge clk);
        #1;
        m_pc  = 32'h0;
        m_vld = 1'b0;
        m_mis = 1'b0;
        m_cnt = 32'h0;
        sbq.delete();

        for (int c = 0; c < 400; c++) begin
            logic        re;
            logic        rdy;
            logic [31:0] ra;
            @(negedge clk);
            re  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
            reset             = 1'b0;
            bus.redirect_en   = re;
            bus.redirect_addr = ra;
            bus.out_ready     = rdy;
            #1;
            // Handoff this edge: the held word must be the oldest scoreboard entry.
            if (m_vld && rdy) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty cycle=%0d actual_pc=%h required=entry", c, bus.if_pc);
                end else begin
                    logic [63:0] e;
                    e = sbq.pop_front();
                    chk($sformatf("sb_pc_c%0d", c),    bus.if_pc,    e[63:32]);
                    chk($sformatf("sb_instr_c%0d", c), bus.if_instr, e[31:0]);
                end
                m_cnt = m_cnt + 32'd1;
            end
            if (re) begin
                m_pc  = {ra[31:2], 2'b00};
                m_vld = 1'b0;
                m_mis = (ra[1:0] != 2'b00);
                sbq.delete();
            end else if (!m_vld || rdy) begin
                sbq.push_back({m_pc, rom_word(m_pc)});
                m_pc  = m_pc + 32'd4;
                m_vld = 1'b1;
                m_mis = 1'b0;
            end else begin
                m_mis = 1'b0;
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd_valid_c%0d", c), {31'd0, bus.out_valid},    {31'd0, m_vld});
            chk($sformatf("rnd_addr_c%0d", c),  bus.instr_addr,            m_pc);
            chk($sformatf("rnd_mis_c%0d", c),   {31'd0, bus.misalign_err}, {31'd0, m_mis});
            chk($sformatf("rnd_cnt_c%0d", c),   bus.fetch_count,           m_cnt);
            if (!m_vld) chk($sformatf("rnd_nop_c%0d", c), bus.if_instr, NOP);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
